// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-based imem requests, decode-side FIFO
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_FAULT = 1'b1;

    logic [0:0]    state;
    logic [31:0]   pc;
    logic [31:0]   rspPc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [31:0]   dataMem [FIFO_DEPTH];
    logic [31:0]   pcMem   [FIFO_DEPTH];

    logic [31:0] target;
    logic        misaligned;

`ifdef MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign misaligned = |redirect_pc[1:0];
`else
    logic unusedTargetBits;
    assign unusedTargetBits = ^redirect_pc[1:0];
    assign target           = {redirect_pc[31:2], 2'b00};
    assign misaligned       = 1'b0;
`endif

    logic [CW:0] credit;
    logic        reqFire;
    logic        popFire;
    logic        keepRsp;
    logic        dropRsp;

    // Every in-flight or buffered fetch holds a slot, so a response can always be pushed.
    assign credit         = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && (state == STATE_RUN) && !redirect && (credit < DEPTH_CNT);
    assign imem_req_addr  = pc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign inst_valid = (count != '0);
    assign inst       = dataMem[rdPtr];
    assign inst_pc    = pcMem[rdPtr];
    assign popFire    = inst_valid && inst_ready;

    assign keepRsp = imem_rsp_valid && !redirect && (drop == '0);
    assign dropRsp = imem_rsp_valid && !redirect && (drop != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STATE_RUN;
            pc          <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else if (redirect) begin
            // Whatever is still in flight after this edge belongs to the wrong path.
            state       <= misaligned ? STATE_FAULT : STATE_RUN;
            pc          <= target;
            rspPc       <= target;
            outstanding <= outstanding - CW'(imem_rsp_valid);
            drop        <= outstanding - CW'(imem_rsp_valid);
            count       <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
        end else begin
            if (reqFire) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + CW'(reqFire) - CW'(imem_rsp_valid);
            if (dropRsp) begin
                drop <= drop - CW'(1);
            end
            if (keepRsp) begin
                rspPc <= rspPc + 32'd4;
                wrPtr <= wrPtr + PW'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(keepRsp) - CW'(popFire);
        end
    end

    always_ff @(posedge clk) begin
        if (keepRsp) begin
            dataMem[wrPtr] <= imem_rsp_data;
            pcMem[wrPtr]   <= rspPc;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign fetch_fault = (state == STATE_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a variable-latency in-order memory

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;
    int memLat = 1;
    int relCyc = 0;

    logic [31:0] pendAddr[$];
    int          pendDue[$];
    logic [31:0] reqLog[$];
    logic [31:0] popPc[$];
    logic [31:0] popData[$];
    int          popCyc[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    // Memory: returns accepted fetches in order, memLat cycles after acceptance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pendAddr.delete();
                pendDue.delete();
                imem_rsp_valid = 1'b0;
            end else if (pendAddr.size() > 0 && pendDue[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memData(pendAddr[0]);
                void'(pendAddr.pop_front());
                void'(pendDue.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                reqLog.push_back(imem_req_addr);
                pendAddr.push_back(imem_req_addr);
                pendDue.push_back(cyc + memLat);
            end
            if (!rst && inst_valid && inst_ready) begin
                popPc.push_back(inst_pc);
                popData.push_back(inst);
                popCyc.push_back(cyc);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) nextCycle();
    endtask

    task automatic sampleNow();
        @(negedge clk);
    endtask

    task automatic clearLogs();
        reqLog.delete();
        popPc.delete();
        popData.delete();
        popCyc.delete();
    endtask

    task automatic releaseReset(input int lat);
        nextCycle();
        rst = 1'b1;
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        memLat = lat;
        nextCycle();
        nextCycle();
        clearLogs();
        rst = 1'b0;
        relCyc = cyc;
    endtask

    task automatic waitPops(input int need, input string name);
        int n = 0;
        while (popPc.size() < need && n < 60) begin
            nextCycle();
            n++;
        end
        nVec++;
        if (popPc.size() < need) begin
            $display("FAIL %s_timeout: got %0d instructions, expected %0d", name, popPc.size(), need);
            nErr++;
        end
    endtask

    task automatic test_reset();
        waitCycles(2);
        sampleNow();
        nVec++; if (imem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid: got %b, expected 0", imem_req_valid); nErr++; end
        nVec++; if (inst_valid !== 1'b0) begin $display("FAIL reset_inst_valid: got %b, expected 0", inst_valid); nErr++; end
        nVec++; if (fetch_fault !== 1'b0) begin $display("FAIL reset_fetch_fault: got %b, expected 0", fetch_fault); nErr++; end
        nVec++; if (imem_req_addr !== 32'h0) begin $display("FAIL reset_req_addr: got %h, expected 00000000", imem_req_addr); nErr++; end
    endtask

    task automatic test_sequential();
        logic [31:0] expPc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] expDat[5] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C, 32'hC0DE_0010};
        releaseReset(1);
        sampleNow();
        nVec++; if (imem_req_valid !== 1'b1) begin $display("FAIL seq_first_req_valid: got %b, expected 1", imem_req_valid); nErr++; end
        nVec++; if (imem_req_addr !== 32'h0) begin $display("FAIL seq_first_req_addr: got %h, expected 00000000", imem_req_addr); nErr++; end
        waitCycles(14);
        waitPops(5, "seq");
        for (int i = 0; i < 5; i++) begin
            if (i < popPc.size()) begin
                nVec++; if (popPc[i] !== expPc[i]) begin $display("FAIL seq_inst_pc[%0d]: got %h, expected %h", i, popPc[i], expPc[i]); nErr++; end
                nVec++; if (popData[i] !== expDat[i]) begin $display("FAIL seq_inst[%0d]: got %h, expected %h", i, popData[i], expDat[i]); nErr++; end
            end
            if (i < reqLog.size()) begin
                nVec++; if (reqLog[i] !== expPc[i]) begin $display("FAIL seq_req_addr[%0d]: got %h, expected %h", i, reqLog[i], expPc[i]); nErr++; end
            end
        end
        if (popCyc.size() > 0) begin
            nVec++; if (popCyc[0] - relCyc !== 2) begin $display("FAIL seq_first_inst_latency: got %0d, expected 2", popCyc[0] - relCyc); nErr++; end
        end
    endtask

    task automatic test_stall();
        logic [31:0] expPc[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        releaseReset(1);
        inst_ready = 1'b0;
        waitCycles(10);
        sampleNow();
        nVec++; if (reqLog.size() !== 2) begin $display("FAIL stall_req_count: got %0d, expected 2", reqLog.size()); nErr++; end
        nVec++; if (imem_req_valid !== 1'b0) begin $display("FAIL stall_req_valid: got %b, expected 0", imem_req_valid); nErr++; end
        nVec++; if (inst_valid !== 1'b1) begin $display("FAIL stall_inst_valid: got %b, expected 1", inst_valid); nErr++; end
        nVec++; if (inst !== 32'hC0DE_0000) begin $display("FAIL stall_inst_hold: got %h, expected c0de0000", inst); nErr++; end
        nVec++; if (inst_pc !== 32'h0) begin $display("FAIL stall_inst_pc_hold: got %h, expected 00000000", inst_pc); nErr++; end
        nextCycle();
        inst_ready = 1'b1;
        waitCycles(14);
        waitPops(5, "stall_release");
        for (int i = 0; i < 5; i++) begin
            if (i < popPc.size()) begin
                nVec++; if (popPc[i] !== expPc[i]) begin $display("FAIL stall_release_pc[%0d]: got %h, expected %h", i, popPc[i], expPc[i]); nErr++; end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        releaseReset(3);
        waitCycles(2);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        sampleNow();
        nVec++; if (reqLog.size() !== 2) begin $display("FAIL inflight_req_count: got %0d, expected 2", reqLog.size()); nErr++; end
        nVec++; if (imem_req_valid !== 1'b0) begin $display("FAIL inflight_req_valid_on_redirect: got %b, expected 0", imem_req_valid); nErr++; end
        nextCycle();
        redirect = 1'b0;
        waitPops(2, "inflight");
        if (popPc.size() >= 2) begin
            nVec++; if (popPc[0] !== 32'h100) begin $display("FAIL inflight_first_pc: got %h, expected 00000100", popPc[0]); nErr++; end
            nVec++; if (popData[0] !== 32'hC0DE_0100) begin $display("FAIL inflight_first_inst: got %h, expected c0de0100", popData[0]); nErr++; end
            nVec++; if (popPc[1] !== 32'h104) begin $display("FAIL inflight_second_pc: got %h, expected 00000104", popPc[1]); nErr++; end
        end
        if (reqLog.size() >= 3) begin
            nVec++; if (reqLog[2] !== 32'h100) begin $display("FAIL inflight_req_after_redirect: got %h, expected 00000100", reqLog[2]); nErr++; end
        end
    endtask

    task automatic test_redirect_collide();
        int rdCyc;
        releaseReset(1);
        waitCycles(2);
        redirect = 1'b1;
        redirect_pc = 32'h180;
        rdCyc = cyc;
        sampleNow();
        nVec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin $display("FAIL collide_pop_pre: got valid=%b pc=%h, expected valid=1 pc=00000000", inst_valid, inst_pc); nErr++; end
        nextCycle();
        redirect = 1'b0;
        sampleNow();
        nVec++; if (inst_valid !== 1'b0) begin $display("FAIL collide_fifo_empty: got %b, expected 0", inst_valid); nErr++; end
        nVec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h180) begin $display("FAIL collide_req: got valid=%b addr=%h, expected valid=1 addr=00000180", imem_req_valid, imem_req_addr); nErr++; end
        waitPops(3, "collide");
        if (popPc.size() >= 3) begin
            nVec++; if (popPc[0] !== 32'h0) begin $display("FAIL collide_popped_pc: got %h, expected 00000000", popPc[0]); nErr++; end
            nVec++; if (popPc[1] !== 32'h180) begin $display("FAIL collide_target_pc: got %h, expected 00000180", popPc[1]); nErr++; end
            nVec++; if (popPc[2] !== 32'h184) begin $display("FAIL collide_target_next_pc: got %h, expected 00000184", popPc[2]); nErr++; end
            nVec++; if (popCyc[1] - rdCyc !== 3) begin $display("FAIL collide_redirect_latency: got %0d, expected 3", popCyc[1] - rdCyc); nErr++; end
        end
    endtask

    task automatic test_ready_toggle();
        logic [31:0] prevAddr = 32'h0;
        logic        prevStall = 1'b0;
        int          holds = 0;
        releaseReset(3);
        for (int i = 0; i < 48; i++) begin
            imem_req_ready = ((i % 4) == 0) || ((i % 4) == 3);
            sampleNow();
            if (prevStall) begin
                holds++;
                nVec++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prevAddr) begin
                    $display("FAIL toggle_addr_hold[%0d]: got valid=%b addr=%h, expected valid=1 addr=%h", i, imem_req_valid, imem_req_addr, prevAddr);
                    nErr++;
                end
            end
            prevStall = imem_req_valid && !imem_req_ready;
            prevAddr  = imem_req_addr;
            nextCycle();
        end
        imem_req_ready = 1'b1;
        nVec++; if (holds < 4) begin $display("FAIL toggle_stall_count: got %0d, expected at least 4", holds); nErr++; end
        waitPops(8, "toggle");
        for (int i = 0; i < popPc.size(); i++) begin
            nVec++;
            if (popPc[i] !== 32'(4 * i) || popData[i] !== 32'hC0DE_0000 + 32'(4 * i)) begin
                $display("FAIL toggle_order[%0d]: got pc=%h inst=%h, expected pc=%h inst=%h", i, popPc[i], popData[i], 32'(4 * i), 32'hC0DE_0000 + 32'(4 * i));
                nErr++;
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] expTarget;
        releaseReset(1);
        waitCycles(5);
        imem_req_ready = 1'b0;
        waitCycles(4);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        sampleNow();
        nVec++; if (imem_req_valid !== 1'b0) begin $display("FAIL misalign_no_req_on_redirect: got %b, expected 0", imem_req_valid); nErr++; end
        nextCycle();
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        clearLogs();
`ifdef MISALIGN_TRAP_EN
        sampleNow();
        nVec++; if (fetch_fault !== 1'b1) begin $display("FAIL misalign_fault_set: got %b, expected 1", fetch_fault); nErr++; end
        nVec++; if (imem_req_valid !== 1'b0) begin $display("FAIL misalign_req_blocked: got %b, expected 0", imem_req_valid); nErr++; end
        nVec++; if (imem_req_addr !== 32'h102) begin $display("FAIL misalign_pc_hold: got %h, expected 00000102", imem_req_addr); nErr++; end
        waitCycles(5);
        sampleNow();
        nVec++; if (reqLog.size() !== 0) begin $display("FAIL misalign_req_count: got %0d, expected 0", reqLog.size()); nErr++; end
        nVec++; if (fetch_fault !== 1'b1) begin $display("FAIL misalign_fault_sticky: got %b, expected 1", fetch_fault); nErr++; end
        nextCycle();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        nextCycle();
        redirect = 1'b0;
        sampleNow();
        nVec++; if (fetch_fault !== 1'b0) begin $display("FAIL misalign_fault_clear: got %b, expected 0", fetch_fault); nErr++; end
        nVec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin $display("FAIL misalign_resume_req: got valid=%b addr=%h, expected valid=1 addr=00000200", imem_req_valid, imem_req_addr); nErr++; end
        expTarget = 32'h200;
`else
        sampleNow();
        nVec++; if (fetch_fault !== 1'b0) begin $display("FAIL align_fault_tied: got %b, expected 0", fetch_fault); nErr++; end
        nVec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin $display("FAIL align_forced_req: got valid=%b addr=%h, expected valid=1 addr=00000100", imem_req_valid, imem_req_addr); nErr++; end
        expTarget = 32'h100;
`endif
        waitPops(2, "misalign");
        if (popPc.size() >= 2) begin
            nVec++; if (popPc[0] !== expTarget) begin $display("FAIL misalign_first_pc: got %h, expected %h", popPc[0], expTarget); nErr++; end
            nVec++; if (popPc[1] !== expTarget + 32'd4) begin $display("FAIL misalign_second_pc: got %h, expected %h", popPc[1], expTarget + 32'd4); nErr++; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_ready_toggle();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; owns the PC.
- Consumes the branch/jump decision (take flag + target) produced by the jump-control logic in execute.
- Issues word fetches to instruction memory over a valid/ready request channel and collects in-order responses.
- Buffers fetched instructions in a small FIFO toward decode and squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the max in-flight + buffered fetches (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  taken branch/jump from jump control (shouldJump).
- redirect_pc  in  32  branch/jump target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch byte address (word aligned).
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after accept, never back-pressured.
- imem_rsp_data  in  32  fetched instruction.
- inst_valid  out  1  decode-side instruction valid.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- fetch_fault  out  1  misaligned target trap; only with MISALIGN_TRAP_EN, otherwise tied 0.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, rsp_pc=RESET_PC.
  - outstanding=0, drop=0, FIFO empty.
  - state=RUN, imem_req_valid=0, inst_valid=0, fetch_fault=0.
- Registers:
  - pc: next request address.
  - rsp_pc: PC tag of the next non-stale response.
  - outstanding: in-flight count, stale included.
  - drop: stale in-flight count.
  - count: FIFO occupancy.
- FSM states:
  - RUN: normal fetch.
  - FAULT: no requests issued; exit only via a valid redirect.
- Request rule: imem_req_valid = (state==RUN) && !redirect && (outstanding + count < FIFO_DEPTH).
  - imem_req_addr = pc.
  - On handshake (valid && ready): pc += 4 (wraps mod 2^32); outstanding += 1.
  - This credit scheme guarantees a FIFO slot for every response.
- Response, no redirect this cycle:
  - outstanding -= 1.
  - If drop>0: discard and drop -= 1.
  - Else: push {imem_rsp_data, rsp_pc} into the FIFO; rsp_pc += 4.
- Simultaneous request handshake and response: outstanding is unchanged.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle leaves count unchanged.
- inst, inst_pc and inst_valid are registered FIFO head outputs, stable while inst_valid && !inst_ready.
- Redirect (redirect=1), effective next edge:
  - pc <= redirect_pc, rsp_pc <= redirect_pc.
  - FIFO cleared. A pop in the same cycle still counts as consumed.
  - Any response arriving that cycle is discarded.
  - drop <= outstanding - imem_rsp_valid; outstanding <= outstanding - imem_rsp_valid.
  - No request is issued in the redirect cycle.
- Latency (1-cycle memory, ready=1):
  - Redirect at cycle N → request redirect_pc at N+1 → response at N+2 → inst_valid with inst_pc=redirect_pc at N+3.
- Steady state: one instruction per cycle when memory and decode never stall.
- Reset mid-transfer: all counters clear immediately. Responses arriving after reset release for fetches issued before reset are forbidden; the environment guarantees this.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 moves state to FAULT.
  - fetch_fault is set, FIFO flushed, all in-flight marked stale.
  - pc holds the misaligned target for debug.
  - A later aligned redirect returns to RUN and clears fetch_fault.
- Undefined: redirect_pc[1:0] is forced to 2'b00, FAULT is unreachable, fetch_fault=0.

Test Plan:
- Reset release, ready=1, 1-cycle memory, inst_ready=1 → addresses 0x0,0x4,0x8… consecutive; inst_valid from cycle 3; inst_pc matches imem_req_addr of the same fetch.
- inst_ready=0 for 10 cycles → ≤2 requests issued, then imem_req_valid=0; inst holds 0x0 data; release → sequence resumes without loss or duplication.
- Redirect to 0x100 while 2 fetches in flight → both responses dropped; next inst_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and a pop → popped instruction consumed once; response discarded; FIFO empty; first new inst_pc=target.
- imem_req_ready toggling 1,0,0,1 with 3-cycle latency → address held while ready=0; no overflow; in-order delivery.
- MISALIGN_TRAP_EN defined: redirect to 0x102 → fetch_fault=1, no requests; redirect to 0x200 → fetch_fault=0, fetch resumes at 0x200. Undefined: the same stimulus fetches from 0x100.
